// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter with lock ownership and lock timeout
// Define DMEM_ARB_RR_EN for round-robin arbitration in IDLE; fixed priority r0 > r1 otherwise.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  input  logic              r0_lock,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [31:0]       r0_rdata,

  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  input  logic              r1_lock,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [31:0]       r1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,

  output logic              lock_err
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] lock_cnt;
  logic             blk0;
  logic             blk1;
  logic             lock0_eff;
  logic             lock1_eff;
  logic             pick0;
  logic             cnt_done;

  // A timed-out requester's lock is ignored until it lets go of r*_lock.
  assign lock0_eff = r0_lock & ~blk0;
  assign lock1_eff = r1_lock & ~blk1;
  assign cnt_done  = (lock_cnt == CNT_LAST);

`ifdef DMEM_ARB_RR_EN
  logic rr_last;

  // rr_last names the requester granted most recently in IDLE; the other wins a conflict.
  always_comb begin
    pick0 = r0_req & (~r1_req | rr_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (state == IDLE) begin
      if (r0_gnt) begin
        rr_last <= 1'b0;
      end else if (r1_gnt) begin
        rr_last <= 1'b1;
      end
    end
  end
`else
  always_comb begin
    pick0 = r0_req;
  end
`endif

  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          r0_gnt = pick0;
          r1_gnt = r1_req & ~pick0;
        end
        OWN0:    r0_gnt = r0_req;
        OWN1:    r1_gnt = r1_req;
        default: begin
          r0_gnt = 1'b0;
          r1_gnt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (r0_gnt) begin
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
      mem_we    = r0_we;
    end else if (r1_gnt) begin
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
      mem_we    = r1_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      blk0      <= 1'b0;
      blk1      <= 1'b0;
      lock_err  <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      lock_err  <= 1'b0;
      r0_rvalid <= r0_gnt & ~r0_we;
      r1_rvalid <= r1_gnt & ~r1_we;
      if (r0_gnt && !r0_we) begin
        r0_rdata <= mem_rdata;
      end
      if (r1_gnt && !r1_we) begin
        r1_rdata <= mem_rdata;
      end
      if (!r0_lock) begin
        blk0 <= 1'b0;
      end
      if (!r1_lock) begin
        blk1 <= 1'b0;
      end

      case (state)
        IDLE: begin
          lock_cnt <= '0;
          if (r0_gnt && lock0_eff) begin
            state <= OWN0;
          end else if (r1_gnt && lock1_eff) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          if (!r0_lock) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (cnt_done) begin
            state    <= IDLE;
            lock_cnt <= '0;
            lock_err <= 1'b1;
            blk0     <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        OWN1: begin
          if (!r1_lock) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (cnt_done) begin
            state    <= IDLE;
            lock_cnt <= '0;
            lock_err <= 1'b1;
            blk1     <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule
